sleep_ctrl_mc: RTL and testbench
================================

SLEEP_CTRL_MC -- requirements
Module: sleep_ctrl_mc

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 12, APB slave address width (4 KB window).
REQ-002 SHALL have parameter NUM_CORES, default 2, number of independently controlled cores (legal range 1..16).
REQ-003 SHALL have parameter SHDN_TIMEOUT, default 1024, maximum number of cycles spent in SHUTDOWN before abort (legal range 2..65535).
REQ-004 SHALL have port HCLK, input, 1, clock.
REQ-005 SHALL have port HRESETn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have APB slave ports PADDR (APB_ADDR_WIDTH), PWDATA (32), PWRITE, PSEL, PENABLE as inputs, and PRDATA (32), PREADY, PSLVERR as outputs.
REQ-007 SHALL have ports irq_i, event_i, core_busy_i, all input, NUM_CORES wide, giving per-core interrupt, event and busy.
REQ-008 SHALL have ports fetch_en_o and clk_gate_core_o, both output, NUM_CORES wide; fetch_en_o is the per-core fetch enable and clk_gate_core_o the per-core clock enable (low means gated).
REQ-009 SHALL have port timer_wake_o, output, 1, a one-cycle pulse when the wake timer expires.

Function
REQ-010 SHALL tie PREADY=1 and PSLVERR=0; a write commits on PSEL&PENABLE&PWRITE, and PRDATA is driven on PSEL&PENABLE&~PWRITE and is 0 otherwise.
REQ-011 SHALL decode the register index as PADDR[5:2]: 0 CTRL, 1 STATUS, 2 WAKE_TIMER, 3 TIMER_MASK; other indices read 0 and ignore writes.
REQ-012 CTRL SHALL be read/write, with bit i as the sleep-enable for core i; bits at NUM_CORES and above SHALL read 0.
REQ-013 STATUS SHALL hold sleeping flags in bits[NUM_CORES-1:0] (read-only, updated every cycle from the FSM) and sticky timeout flags in bits[16+NUM_CORES-1:16] (write-1-to-clear).
REQ-014 TIMER_MASK bit i SHALL select whether a timer expiry wakes core i.
REQ-015 WAKE_TIMER SHALL be a 32-bit read/write countdown: when nonzero it decrements by 1 per HCLK; the 1->0 transition SHALL raise timer_wake_o for exactly one cycle.
REQ-016 An APB write to WAKE_TIMER in the same cycle as the 1->0 transition SHALL load the written value and suppress the pulse; reads SHALL return the current count.
REQ-017 The per-core wake is defined as wake[i] = event_i[i] | (timer_wake_o & TIMER_MASK[i]).
REQ-018 Each core SHALL have an independent FSM with states RUN, SHUTDOWN and SLEEP.
REQ-019 RUN: the FSM SHALL move to SHUTDOWN when CTRL[i] & ~wake[i]; fetch_en_o[i] = ~(CTRL[i] & ~wake[i]), combinational; clk_gate_core_o[i]=1.
REQ-020 SHUTDOWN: wake[i] -> RUN; else ~core_busy_i[i] & ~irq_i[i] -> SLEEP; else a cycle counter reaching SHDN_TIMEOUT-1 -> RUN with timeout flag i set; fetch_en_o[i]=0; clk_gate_core_o[i]=1.
REQ-021 The SHUTDOWN cycle counter SHALL be 16 bits, cleared on every entry to SHUTDOWN, and saturate (no wrap).
REQ-022 SLEEP: wake[i] -> RUN; else irq_i[i] -> SHUTDOWN; fetch_en_o[i]=0; clk_gate_core_o[i]=wake[i], combinational, so the clock is restored in the wake cycle; sleeping flag i=1.
REQ-023 Any illegal state encoding SHALL go to RUN on the next cycle.
REQ-024 CTRL[i] SHALL be hardware-cleared in a cycle where core i is in SLEEP, wake[i]=1, or a timeout aborts core i.
REQ-025 An APB write to CTRL in that same cycle SHALL take precedence over the hardware clear.
REQ-026 If a hardware set and a W1C of a timeout flag coincide, the set SHALL win.
REQ-027 Cores SHALL not interact except through the shared timer and shared registers.

Reset
REQ-028 On HRESETn low, all FSMs SHALL go to RUN, all registers and counters to 0, and timer_wake_o to 0.
REQ-029 During reset the outputs SHALL be fetch_en_o=all 1, clk_gate_core_o=all 1, PRDATA=0.
REQ-030 Reset asserted mid-SLEEP SHALL immediately restore clk_gate_core_o=1 for all cores.

Verification
REQ-031 Write CTRL=0x1 with core0 busy=0, irq=0 -> core0 FSM RUN->SHUTDOWN->SLEEP, clk_gate_core_o[0]=0, STATUS[0]=1, CTRL[0] cleared, core1 outputs unchanged.
REQ-032 Core0 in SLEEP, event_i[0] pulses 1 cycle -> clk_gate_core_o[0]=1 in that same cycle, FSM in RUN next cycle, fetch_en_o[0]=1.
REQ-033 TIMER_MASK=0x2, WAKE_TIMER=5, core1 asleep -> timer_wake_o pulses 5 cycles later and core1 wakes; core0 stays asleep.
REQ-034 Core0 in SHUTDOWN with busy held at 1 and SHDN_TIMEOUT=16 -> returns to RUN after 16 cycles, STATUS[16]=1, CTRL[0]=0; W1C of 0x10000 clears the flag.
REQ-035 Core0 in SLEEP, irq_i[0]=1 with busy=1 -> SHUTDOWN with clock enabled; busy dropping then irq dropping -> SLEEP again.
REQ-036 A CTRL write coinciding with the hardware clear -> the written value is retained; HRESETn asserted mid-SLEEP -> clk_gate_core_o=all 1 immediately.

Source files
------------

// File: rtl/sleep_ctrl_mc_if.sv
// ----------------------------------------------------------------------------
// sleep_ctrl_mc_if
// APB bus bundle between a bus master and the sleep controller's register
// block.
//   PADDR   : register address (APB_ADDR_WIDTH bits)
//   PWDATA  : write data (32 bits)
//   PWRITE  : 1 = write, 0 = read
//   PSEL    : slave select
//   PENABLE : access phase strobe
//   PRDATA  : read data (32 bits), from slave
//   PREADY  : transfer ready, from slave
//   PSLVERR : transfer error, from slave
// ----------------------------------------------------------------------------
interface sleep_ctrl_mc_if #(
    parameter int APB_ADDR_WIDTH = 12
);
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/sleep_ctrl_mc.sv
// ----------------------------------------------------------------------------
// sleep_ctrl_mc
// Multi-core sleep controller. Each core has its own RUN / SHUTDOWN / SLEEP
// state machine that drains the core (fetch disabled) before gating its
// clock, and wakes it on an event or on expiry of a shared wake timer.
//
// Ports:
//   HCLK, HRESETn    : clock, asynchronous active-low reset
//   apb              : APB slave (CTRL, STATUS, WAKE_TIMER, TIMER_MASK)
//   irq_i            : per-core interrupt pending
//   event_i          : per-core wake event
//   core_busy_i      : per-core busy (outstanding work during drain)
//   fetch_en_o       : per-core instruction fetch enable
//   clk_gate_core_o  : per-core clock enable, low = clock gated
//   timer_wake_o     : one-cycle pulse on wake timer expiry
//
// Register map (index = PADDR[5:2]):
//   0 CTRL        RW   bit i = sleep request for core i, self-clearing
//   1 STATUS      [N-1:0] sleeping (RO), [16+N-1:16] timeout flags (W1C)
//   2 WAKE_TIMER  RW   32-bit countdown
//   3 TIMER_MASK  RW   bit i = timer expiry wakes core i
// ----------------------------------------------------------------------------
module sleep_ctrl_mc #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_CORES      = 2,
    parameter int SHDN_TIMEOUT   = 1024
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    sleep_ctrl_mc_if.slave       apb,
    input  logic [NUM_CORES-1:0] irq_i,
    input  logic [NUM_CORES-1:0] event_i,
    input  logic [NUM_CORES-1:0] core_busy_i,
    output logic [NUM_CORES-1:0] fetch_en_o,
    output logic [NUM_CORES-1:0] clk_gate_core_o,
    output logic                 timer_wake_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SHUTDOWN = 2'b01,
        ST_SLEEP    = 2'b10
    } core_state_e;

    localparam logic [3:0]  IDX_CTRL   = 4'd0;
    localparam logic [3:0]  IDX_STATUS = 4'd1;
    localparam logic [3:0]  IDX_TIMER  = 4'd2;
    localparam logic [3:0]  IDX_MASK   = 4'd3;
    localparam logic [15:0] SHDN_LAST  = 16'(SHDN_TIMEOUT - 1);

    // ------------------------------------------------------------------
    // APB decode
    // ------------------------------------------------------------------
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [3:0]                reg_idx;
    logic                      wr_en;
    logic                      rd_en;
    logic                      wr_ctrl;
    logic                      wr_status;
    logic                      wr_timer;
    logic                      wr_mask;
    logic                      unused_addr;

    assign paddr       = apb.PADDR;
    assign reg_idx     = paddr[5:2];
    assign unused_addr = ^paddr;
    assign wr_en       = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign rd_en       = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
    assign wr_ctrl     = wr_en && (reg_idx == IDX_CTRL);
    assign wr_status   = wr_en && (reg_idx == IDX_STATUS);
    assign wr_timer    = wr_en && (reg_idx == IDX_TIMER);
    assign wr_mask     = wr_en && (reg_idx == IDX_MASK);

    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = 1'b0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    core_state_e          state_q    [NUM_CORES];
    core_state_e          state_d    [NUM_CORES];
    logic [15:0]          shdn_cnt_q [NUM_CORES];
    logic [NUM_CORES-1:0] ctrl_q;
    logic [NUM_CORES-1:0] mask_q;
    logic [NUM_CORES-1:0] tflag_q;
    logic [31:0]          timer_q;

    logic [NUM_CORES-1:0] wake;
    logic [NUM_CORES-1:0] sleeping;
    logic [NUM_CORES-1:0] abort;
    logic [NUM_CORES-1:0] hw_clr;
    logic [NUM_CORES-1:0] tflag_w1c;

    assign wake      = event_i | ({NUM_CORES{timer_wake_o}} & mask_q);
    assign hw_clr    = sleeping | wake | abort;
    assign tflag_w1c = wr_status ? apb.PWDATA[16 +: NUM_CORES] : '0;

    // ------------------------------------------------------------------
    // Per-core FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default before the case so
        // no path leaves a value held, which would infer a latch.
        for (int i = 0; i < NUM_CORES; i++) begin
            state_d[i]         = state_q[i];
            fetch_en_o[i]      = 1'b1;
            clk_gate_core_o[i] = 1'b1;
            abort[i]           = 1'b0;
            sleeping[i]        = 1'b0;

            case (state_q[i])
                ST_RUN: begin
                    // Fetch is cut in the same cycle the request is seen.
                    fetch_en_o[i] = ~(ctrl_q[i] & ~wake[i]);
                    if (ctrl_q[i] && !wake[i]) begin
                        state_d[i] = ST_SHUTDOWN;
                    end
                end
                ST_SHUTDOWN: begin
                    fetch_en_o[i] = 1'b0;
                    if (wake[i]) begin
                        state_d[i] = ST_RUN;
                    end else if (!core_busy_i[i] && !irq_i[i]) begin
                        state_d[i] = ST_SLEEP;
                    end else if (shdn_cnt_q[i] == SHDN_LAST) begin
                        state_d[i] = ST_RUN;
                        abort[i]   = 1'b1;
                    end
                end
                ST_SLEEP: begin
                    fetch_en_o[i]      = 1'b0;
                    sleeping[i]        = 1'b1;
                    // Clock comes back in the wake cycle itself.
                    clk_gate_core_o[i] = wake[i];
                    if (wake[i]) begin
                        state_d[i] = ST_RUN;
                    end else if (irq_i[i]) begin
                        state_d[i] = ST_SHUTDOWN;
                    end
                end
                default: begin
                    state_d[i] = ST_RUN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Per-core state register and drain counter
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        // NOTE: the per-core arrays are a handful of flops, not a RAM, so
        // every element is reset like any other register.
        if (!HRESETn) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                state_q[i]    <= ST_RUN;
                shdn_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                // NOTE: non-blocking assignments keep every flop sampling the
                // pre-edge values regardless of statement order.
                state_q[i] <= state_d[i];
                // Held at zero outside SHUTDOWN, so every entry starts at 0.
                if (state_q[i] == ST_SHUTDOWN) begin
                    if (shdn_cnt_q[i] != 16'hFFFF) begin
                        shdn_cnt_q[i] <= shdn_cnt_q[i] + 16'd1;
                    end
                end else begin
                    shdn_cnt_q[i] <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers and wake timer
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ctrl_q       <= '0;
            mask_q       <= '0;
            tflag_q      <= '0;
            timer_q      <= '0;
            timer_wake_o <= 1'b0;
        end else begin
            // A software write beats the hardware clear in the same cycle.
            if (wr_ctrl) begin
                ctrl_q <= apb.PWDATA[NUM_CORES-1:0];
            end else begin
                ctrl_q <= ctrl_q & ~hw_clr;
            end

            if (wr_mask) begin
                mask_q <= apb.PWDATA[NUM_CORES-1:0];
            end

            // Set wins over a coincident write-1-to-clear.
            tflag_q <= (tflag_q & ~tflag_w1c) | abort;

            if (wr_timer) begin
                timer_q <= apb.PWDATA;
            end else if (timer_q != 32'd0) begin
                timer_q <= timer_q - 32'd1;
            end

            // Pulse accompanies the 1->0 step; a reload in that cycle cancels it.
            timer_wake_o <= (timer_q == 32'd1) && !wr_timer;
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [31:0] prdata;

    always_comb begin
        prdata = '0;
        if (rd_en) begin
            case (reg_idx)
                IDX_CTRL:   prdata[NUM_CORES-1:0] = ctrl_q;
                IDX_STATUS: begin
                    prdata[NUM_CORES-1:0]    = sleeping;
                    prdata[16 +: NUM_CORES]  = tflag_q;
                end
                IDX_TIMER:  prdata = timer_q;
                IDX_MASK:   prdata[NUM_CORES-1:0] = mask_q;
                default:    prdata = '0;
            endcase
        end
    end

    assign apb.PRDATA = prdata;

endmodule

// File: tb/tb_sleep_ctrl_mc.sv
// ----------------------------------------------------------------------------
// tb_sleep_ctrl_mc
// Self-checking bench for sleep_ctrl_mc (2 cores, 16-cycle drain timeout).
// A behavioural model of the cores, registers and timer is stepped once per
// clock alongside the DUT; outputs are compared 1 ns after each falling edge.
// Directed scenarios come first, then a randomized stretch.
// ----------------------------------------------------------------------------
module tb_sleep_ctrl_mc;

    localparam int N  = 2;
    localparam int T  = 16;
    localparam int AW = 12;

    localparam int RUNNING  = 0;
    localparam int DRAINING = 1;
    localparam int ASLEEP   = 2;

    logic         HCLK    = 1'b0;
    logic         HRESETn = 1'b0;
    logic [N-1:0] irq_i       = '0;
    logic [N-1:0] event_i     = '0;
    logic [N-1:0] core_busy_i = '0;
    logic [N-1:0] fetch_en_o;
    logic [N-1:0] clk_gate_core_o;
    logic         timer_wake_o;

    sleep_ctrl_mc_if #(.APB_ADDR_WIDTH(AW)) apb ();

    sleep_ctrl_mc #(
        .APB_ADDR_WIDTH (AW),
        .NUM_CORES      (N),
        .SHDN_TIMEOUT   (T)
    ) dut (
        .HCLK            (HCLK),
        .HRESETn         (HRESETn),
        .apb             (apb),
        .irq_i           (irq_i),
        .event_i         (event_i),
        .core_busy_i     (core_busy_i),
        .fetch_en_o      (fetch_en_o),
        .clk_gate_core_o (clk_gate_core_o),
        .timer_wake_o    (timer_wake_o)
    );

    always #5 HCLK = ~HCLK;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model
    int           m_mode  [N];
    int           m_drain [N];
    logic [N-1:0] m_ctrl;
    logic [N-1:0] m_mask;
    logic [N-1:0] m_tflag;
    logic [31:0]  m_timer;
    logic         m_pulse;
    logic [31:0]  last_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_mode[i]  = RUNNING;
            m_drain[i] = 0;
        end
        m_ctrl  = '0;
        m_mask  = '0;
        m_tflag = '0;
        m_timer = '0;
        m_pulse = 1'b0;
    endfunction

    function automatic logic [N-1:0] model_wake();
        return event_i | ({N{m_pulse}} & m_mask);
    endfunction

    function automatic logic [31:0] model_rdata();
        logic [31:0] r;
        logic [3:0]  idx;
        r   = '0;
        idx = apb.PADDR[5:2];
        if (apb.PSEL && apb.PENABLE && !apb.PWRITE) begin
            if (idx == 4'd0) r[N-1:0] = m_ctrl;
            if (idx == 4'd1) begin
                for (int i = 0; i < N; i++) r[i] = (m_mode[i] == ASLEEP);
                r[16 +: N] = m_tflag;
            end
            if (idx == 4'd2) r = m_timer;
            if (idx == 4'd3) r[N-1:0] = m_mask;
        end
        return r;
    endfunction

    // One clock: compare outputs against the model, then advance the model
    // with the inputs the DUT samples at the coming rising edge.
    task automatic tick();
        logic [N-1:0] wk, exp_fe, exp_cg, clr, abrt;
        int           n_mode  [N];
        int           n_drain [N];
        logic [N-1:0] n_ctrl, n_mask, n_tflag, w1c;
        logic [31:0]  n_timer;
        logic         n_pulse, wr;
        logic [3:0]   idx;

        #1;
        wk = model_wake();
        for (int i = 0; i < N; i++) begin
            exp_fe[i] = (m_mode[i] == RUNNING) ? !(m_ctrl[i] && !wk[i]) : 1'b0;
            exp_cg[i] = (m_mode[i] == ASLEEP) ? wk[i] : 1'b1;
        end
        check("fetch_en", fetch_en_o, exp_fe);
        check("clk_gate", clk_gate_core_o, exp_cg);
        check("timer_wake", timer_wake_o, m_pulse);
        check("prdata", apb.PRDATA, model_rdata());
        last_rdata = apb.PRDATA;

        for (int i = 0; i < N; i++) begin
            n_mode[i]  = m_mode[i];
            n_drain[i] = m_drain[i];
            abrt[i]    = 1'b0;
            if (m_mode[i] == RUNNING) begin
                if (m_ctrl[i] && !wk[i]) begin
                    n_mode[i]  = DRAINING;
                    n_drain[i] = 0;
                end
            end else if (m_mode[i] == DRAINING) begin
                if (wk[i]) n_mode[i] = RUNNING;
                else if (!core_busy_i[i] && !irq_i[i]) n_mode[i] = ASLEEP;
                else if (m_drain[i] == T - 1) begin
                    n_mode[i] = RUNNING;
                    abrt[i]   = 1'b1;
                end else n_drain[i] = m_drain[i] + 1;
            end else begin
                if (wk[i]) n_mode[i] = RUNNING;
                else if (irq_i[i]) begin
                    n_mode[i]  = DRAINING;
                    n_drain[i] = 0;
                end
            end
            clr[i] = (m_mode[i] == ASLEEP) || wk[i] || abrt[i];
        end

        wr      = apb.PSEL && apb.PENABLE && apb.PWRITE;
        idx     = apb.PADDR[5:2];
        n_ctrl  = (wr && idx == 4'd0) ? apb.PWDATA[N-1:0] : (m_ctrl & ~clr);
        n_mask  = (wr && idx == 4'd3) ? apb.PWDATA[N-1:0] : m_mask;
        w1c     = (wr && idx == 4'd1) ? apb.PWDATA[16 +: N] : '0;
        n_tflag = (m_tflag & ~w1c) | abrt;
        n_timer = (wr && idx == 4'd2) ? apb.PWDATA : ((m_timer != 0) ? m_timer - 1 : 32'd0);
        n_pulse = (m_timer == 32'd1) && !(wr && idx == 4'd2);

        @(posedge HCLK);
        for (int i = 0; i < N; i++) begin
            m_mode[i]  = n_mode[i];
            m_drain[i] = n_drain[i];
        end
        m_ctrl  = n_ctrl;
        m_mask  = n_mask;
        m_tflag = n_tflag;
        m_timer = n_timer;
        m_pulse = n_pulse;
        @(negedge HCLK);
    endtask

    task automatic apb_write(input int idx, input logic [31:0] d);
        apb.PADDR   = AW'(idx << 2);
        apb.PWDATA  = d;
        apb.PWRITE  = 1'b1;
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        tick();
        apb.PENABLE = 1'b1;
        tick();
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
    endtask

    task automatic apb_read(input int idx, output logic [31:0] d);
        apb.PADDR   = AW'(idx << 2);
        apb.PWRITE  = 1'b0;
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        tick();
        apb.PENABLE = 1'b1;
        tick();
        d           = last_rdata;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0]   d;
        int            k;
        int            ph;
        int            idx;
        logic [AW-1:0] a;

        apb.PADDR   = '0;
        apb.PWDATA  = '0;
        apb.PWRITE  = 1'b0;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        model_reset();

        // Reset state
        #12;
        check("rst_fetch", fetch_en_o, 2'b11);
        check("rst_gate", clk_gate_core_o, 2'b11);
        check("rst_timer_wake", timer_wake_o, 1'b0);
        check("rst_prdata", apb.PRDATA, 32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        tick();

        // Core0 sleep entry, core1 untouched
        apb_write(0, 32'h1);
        tick();
        tick();
        check("sleep_gate0", clk_gate_core_o[0], 1'b0);
        check("sleep_core1", {fetch_en_o[1], clk_gate_core_o[1]}, 2'b11);
        apb_read(1, d);
        check("sleep_status", d, 32'h1);
        apb_read(0, d);
        check("sleep_ctrl_cleared", d, 32'h0);

        // Event wake restores the clock in the same cycle
        event_i = 2'b01;
        #1;
        check("event_gate_same_cycle", clk_gate_core_o[0], 1'b1);
        tick();
        event_i = 2'b00;
        check("event_fetch_back", fetch_en_o[0], 1'b1);

        // Timer wakes core1 only
        apb_write(3, 32'h2);
        apb_write(0, 32'h3);
        tick();
        tick();
        apb_write(2, 32'd5);
        k = 0;
        while (!timer_wake_o && k < 20) begin
            tick();
            k++;
        end
        check("timer_delay", k, 5);
        check("timer_gate1", clk_gate_core_o[1], 1'b1);
        check("timer_gate0", clk_gate_core_o[0], 1'b0);
        tick();
        check("timer_core1_run", fetch_en_o[1], 1'b1);
        check("timer_core0_asleep", clk_gate_core_o[0], 1'b0);

        // Drain timeout with core0 busy
        event_i = 2'b01;
        tick();
        event_i     = 2'b00;
        core_busy_i = 2'b01;
        apb_write(0, 32'h1);
        k = 0;
        while (!fetch_en_o[0] && k < 40) begin
            tick();
            k++;
        end
        check("timeout_cycles", k, 17);
        apb_read(1, d);
        check("timeout_flag", d, 32'h0001_0000);
        apb_read(0, d);
        check("timeout_ctrl", d, 32'h0);
        apb_write(1, 32'h0001_0000);
        apb_read(1, d);
        check("timeout_w1c", d, 32'h0);

        // Interrupt during sleep: drain again, then back to sleep
        core_busy_i = 2'b00;
        apb_write(0, 32'h1);
        tick();
        tick();
        irq_i       = 2'b01;
        core_busy_i = 2'b01;
        tick();
        check("irq_gate_on", clk_gate_core_o[0], 1'b1);
        check("irq_fetch_off", fetch_en_o[0], 1'b0);
        core_busy_i = 2'b00;
        tick();
        tick();
        check("irq_still_draining", clk_gate_core_o[0], 1'b1);
        irq_i = 2'b00;
        tick();
        check("irq_resleep", clk_gate_core_o[0], 1'b0);

        // CTRL write coinciding with a wake-driven hardware clear
        apb.PADDR   = AW'(0);
        apb.PWDATA  = 32'h1;
        apb.PWRITE  = 1'b1;
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        tick();
        apb.PENABLE = 1'b1;
        event_i     = 2'b01;
        tick();
        event_i     = 2'b00;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb_read(0, d);
        check("ctrl_write_wins", d, 32'h1);
        tick();
        tick();

        // Reset asserted mid-sleep
        check("pre_reset_gate0", clk_gate_core_o[0], 1'b0);
        apb.PADDR   = AW'(1 << 2);
        apb.PWRITE  = 1'b0;
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b1;
        #2;
        HRESETn = 1'b0;
        #1;
        check("reset_gate_all", clk_gate_core_o, 2'b11);
        check("reset_fetch_all", fetch_en_o, 2'b11);
        check("reset_prdata", apb.PRDATA, 32'h0);
        model_reset();
        @(negedge HCLK);
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        HRESETn     = 1'b1;
        tick();

        // Timer reload in the expiry cycle suppresses the pulse
        apb_write(2, 32'd3);
        tick();
        apb_write(2, 32'd7);
        check("reload_no_pulse", timer_wake_o, 1'b0);
        apb_read(2, d);
        check("reload_count", d, 32'd6);

        // Randomized traffic
        ph = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                event_i[i] = ($urandom_range(0, 15) == 0);
                irq_i[i]   = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 7) == 0) core_busy_i[i] = ~core_busy_i[i];
            end
            if (ph == 1) begin
                apb.PENABLE = 1'b1;
                ph = 2;
            end else begin
                apb.PSEL    = 1'b0;
                apb.PENABLE = 1'b0;
                ph = 0;
                if ($urandom_range(0, 2) == 0) begin
                    idx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 15))
                                                      : int'($urandom_range(0, 3));
                    a       = AW'($urandom);
                    a[5:2]  = 4'(idx);
                    a[1:0]  = 2'b00;
                    apb.PADDR  = a;
                    apb.PWRITE = $urandom_range(0, 1) == 1;
                    apb.PWDATA = (idx == 2) ? 32'($urandom_range(0, 40)) : 32'($urandom);
                    apb.PSEL   = 1'b1;
                    ph = 1;
                end
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
